// File: rtl/l2_port_arbiter_if.sv
// Bundle of both L1 requester ports, the L2 request/response port and status.
// master: the arbiter; slave: the requesters plus the L2 array.
interface l2_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int BLOCK_SIZE = 8
);
  localparam int BW = BLOCK_SIZE * DATA_WIDTH;

  logic [ADDR_WIDTH-1:0] r0_addr;
  logic [BW-1:0]         r0_data_in;
  logic                  r0_read;
  logic                  r0_write;
  logic [BW-1:0]         r0_data_out;
  logic                  r0_hit;
  logic                  r0_done;

  logic [ADDR_WIDTH-1:0] r1_addr;
  logic [BW-1:0]         r1_data_in;
  logic                  r1_read;
  logic                  r1_write;
  logic [BW-1:0]         r1_data_out;
  logic                  r1_hit;
  logic                  r1_done;

  logic [ADDR_WIDTH-1:0] l2_addr;
  logic [BW-1:0]         l2_data_in;
  logic                  l2_read;
  logic                  l2_write;
  logic                  l2_ready;
  logic                  l2_hit;
  logic [BW-1:0]         l2_block_data_out;
  logic                  l2_block_valid;

  logic [1:0]            grant;
  logic                  busy;

  modport master (
    input  r0_addr, r0_data_in, r0_read, r0_write,
    output r0_data_out, r0_hit, r0_done,
    input  r1_addr, r1_data_in, r1_read, r1_write,
    output r1_data_out, r1_hit, r1_done,
    output l2_addr, l2_data_in, l2_read, l2_write,
    input  l2_ready, l2_hit, l2_block_data_out, l2_block_valid,
    output grant, busy
  );

  modport slave (
    output r0_addr, r0_data_in, r0_read, r0_write,
    input  r0_data_out, r0_hit, r0_done,
    output r1_addr, r1_data_in, r1_read, r1_write,
    input  r1_data_out, r1_hit, r1_done,
    input  l2_addr, l2_data_in, l2_read, l2_write,
    output l2_ready, l2_hit, l2_block_data_out, l2_block_valid,
    input  grant, busy
  );
endinterface

// File: rtl/l2_port_arbiter.sv
// Two-requester (L1 I/D) arbiter in front of a single L2 port.
// Define L2_ARB_FIXED_PRIO_EN to make requester 1 always win ties (no round-robin pointer).
module l2_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int BLOCK_SIZE = 8
) (
  input logic clk,
  input logic rst,
  l2_port_arbiter_if.master bus
);
  localparam int BW = BLOCK_SIZE * DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, ISSUE, ACCEPT, COMPLETE, RESP} state_t;

  state_t                state;
  state_t                state_next;
  logic [1:0]            grant_q;
  logic                  op_write;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BW-1:0]         wdata_q;
  logic [BW-1:0]         data0_q;
  logic [BW-1:0]         data1_q;
  logic                  hit0_q;
  logic                  hit1_q;
  logic [1:0]            pending;
  logic                  winner;
  logic                  take;
  logic                  capture;

  assign pending = {bus.r1_read | bus.r1_write, bus.r0_read | bus.r0_write};
  assign take    = (state == IDLE) && (|pending) && bus.l2_ready;
  assign capture = (state == COMPLETE) && bus.l2_ready;

`ifdef L2_ARB_FIXED_PRIO_EN
  assign winner = pending[1];
`else
  // rr_prio names the requester that wins the next tie
  logic rr_prio;

  assign winner = (pending == 2'b11) ? rr_prio : pending[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_prio <= 1'b0;
    end else if (take) begin
      rr_prio <= ~winner;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (take) state_next = ISSUE;
      ISSUE:    state_next = ACCEPT;
      ACCEPT:   if (!bus.l2_ready) state_next = COMPLETE;
      COMPLETE: if (bus.l2_ready) state_next = RESP;
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Read+write together is a write, so the op is just the winner's write bit
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q  <= '0;
      op_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      data0_q  <= '0;
      data1_q  <= '0;
      hit0_q   <= 1'b0;
      hit1_q   <= 1'b0;
    end else begin
      if (take) begin
        grant_q  <= winner ? 2'b10 : 2'b01;
        op_write <= winner ? bus.r1_write : bus.r0_write;
        addr_q   <= winner ? bus.r1_addr : bus.r0_addr;
        wdata_q  <= winner ? bus.r1_data_in : bus.r0_data_in;
      end
      if (capture && grant_q[0]) begin
        data0_q <= bus.l2_block_data_out;
        hit0_q  <= bus.l2_hit;
      end
      if (capture && grant_q[1]) begin
        data1_q <= bus.l2_block_data_out;
        hit1_q  <= bus.l2_hit;
      end
      if (state == RESP) begin
        grant_q <= '0;
      end
    end
  end

  assign bus.l2_addr     = addr_q;
  assign bus.l2_data_in  = wdata_q;
  assign bus.l2_read     = (state == ISSUE) && !op_write;
  assign bus.l2_write    = (state == ISSUE) && op_write;
  assign bus.r0_done     = (state == RESP) && grant_q[0];
  assign bus.r1_done     = (state == RESP) && grant_q[1];
  assign bus.r0_data_out = data0_q;
  assign bus.r1_data_out = data1_q;
  assign bus.r0_hit      = hit0_q;
  assign bus.r1_hit      = hit1_q;
  assign bus.grant       = grant_q;
  assign bus.busy        = (state != IDLE);

  // Block-valid carries no sequencing meaning here
  logic unused_block_valid;
  assign unused_block_valid = bus.l2_block_valid;
endmodule

// File: tb/tb_l2_port_arbiter.sv
// Scoreboard bench for l2_port_arbiter: requester drivers, a behavioural L2 model,
// and monitors that pop expected L2 operations and completions from queues.
module tb_l2_port_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int BS = 8;
  localparam int BW = BS * DW;

  typedef struct {
    int            req;
    bit            write;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
    logic [BW-1:0] rdata;
    bit            hit;
    int            hold;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  txn_t l2_q[$];
  txn_t done_q[$];
  logic [BW-1:0] last_out[2];

  l2_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) bus ();

  l2_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] pat(input logic [7:0] b);
    return {BS{b}};
  endfunction

  function automatic void expectTxn(input int req, input bit write, input logic [AW-1:0] addr,
                                    input logic [BW-1:0] wdata, input logic [BW-1:0] rdata,
                                    input bit hit, input int hold, input bit completes);
    txn_t t;
    t.req = req; t.write = write; t.addr = addr; t.wdata = wdata;
    t.rdata = rdata; t.hit = hit; t.hold = hold;
    l2_q.push_back(t);
    if (completes) done_q.push_back(t);
  endfunction

  task automatic checkResetValues();
    checkOutput("rst_grant", bus.grant, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_l2_read", bus.l2_read, 0);
    checkOutput("rst_l2_write", bus.l2_write, 0);
    checkOutput("rst_done", {bus.r1_done, bus.r0_done}, 0);
    checkOutput("rst_hit", {bus.r1_hit, bus.r0_hit}, 0);
    checkOutput("rst_r0_data_out", bus.r0_data_out, 0);
    checkOutput("rst_r1_data_out", bus.r1_data_out, 0);
    checkOutput("rst_l2_addr", bus.l2_addr, 0);
    checkOutput("rst_l2_data_in", bus.l2_data_in, 0);
  endtask

  task automatic doReset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetValues();
    last_out[0] = '0;
    last_out[1] = '0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Hold the request until done, then drop it after the done cycle
  task automatic applyStimulus(input int n, input bit rd, input bit wr, input logic [AW-1:0] addr,
                               input logic [BW-1:0] data, output int lat);
    int  start;
    bit  got;
    @(posedge clk); #1;
    if (n == 0) begin
      bus.r0_addr = addr; bus.r0_data_in = data; bus.r0_read = rd; bus.r0_write = wr;
    end else begin
      bus.r1_addr = addr; bus.r1_data_in = data; bus.r1_read = rd; bus.r1_write = wr;
    end
    start = cyc;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((n == 0 && bus.r0_done) || (n == 1 && bus.r1_done)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) checkOutput("done_timeout", 0, 1);
    lat = cyc - start + 1;
    @(posedge clk); #1;
    if (n == 0) begin
      bus.r0_read = 1'b0; bus.r0_write = 1'b0;
    end else begin
      bus.r1_read = 1'b0; bus.r1_write = 1'b0;
    end
  endtask

  // L2 model: check each issued op, drop ready while busy, then return block data
  initial begin
    txn_t t;
    bus.l2_ready = 1'b1;
    bus.l2_hit = 1'b0;
    bus.l2_block_data_out = '0;
    bus.l2_block_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && (bus.l2_read || bus.l2_write)) begin
        if (l2_q.size() == 0) begin
          checkOutput("unexpected_l2_op", 1, 0);
        end else begin
          t = l2_q.pop_front();
          checkOutput("l2_write", bus.l2_write, t.write);
          checkOutput("l2_read", bus.l2_read, !t.write);
          checkOutput("l2_addr", bus.l2_addr, t.addr);
          checkOutput("grant", bus.grant, (t.req == 1) ? 2 : 1);
          if (t.write) checkOutput("l2_data_in", bus.l2_data_in, t.wdata);
          @(posedge clk); #1 bus.l2_ready = 1'b0;
          @(negedge clk);
          checkOutput("pulse_width", bus.l2_read | bus.l2_write, 0);
          for (int i = 0; i < t.hold; i++) begin
            if (i > 0) begin
              @(negedge clk);
              if (!rst) begin
                checkOutput("stall_busy", bus.busy, 1);
                checkOutput("stall_addr", bus.l2_addr, t.addr);
                checkOutput("stall_done", bus.r0_done | bus.r1_done, 0);
              end
            end
            @(posedge clk);
            if (rst) break;
          end
          #1;
          bus.l2_block_data_out = t.rdata;
          bus.l2_hit = t.hit;
          bus.l2_block_valid = 1'b1;
          bus.l2_ready = 1'b1;
        end
      end
    end
  end

  // Completion monitor
  initial begin
    txn_t t;
    int   o;
    forever begin
      @(negedge clk);
      if (!rst && (bus.r0_done || bus.r1_done)) begin
        if (done_q.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          t = done_q.pop_front();
          o = 1 - t.req;
          checkOutput("done_owner", {bus.r1_done, bus.r0_done}, (t.req == 1) ? 2 : 1);
          checkOutput("data_out", (t.req == 1) ? bus.r1_data_out : bus.r0_data_out, t.rdata);
          checkOutput("hit", (t.req == 1) ? bus.r1_hit : bus.r0_hit, t.hit);
          checkOutput("other_data_out", (o == 1) ? bus.r1_data_out : bus.r0_data_out, last_out[o]);
          last_out[t.req] = t.rdata;
          @(negedge clk);
          checkOutput("done_width", bus.r0_done | bus.r1_done, 0);
          checkOutput("grant_cleared", bus.grant, 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    rst = 1'b1;
    bus.r0_addr = '0; bus.r0_data_in = '0; bus.r0_read = 1'b0; bus.r0_write = 1'b0;
    bus.r1_addr = '0; bus.r1_data_in = '0; bus.r1_read = 1'b0; bus.r1_write = 1'b0;
    last_out[0] = '0;
    last_out[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues();
    @(posedge clk); #1 rst = 1'b0;

    $display("[TB] single read, minimum latency");
    expectTxn(0, 1'b0, 4'd4, '0, pat(8'hAA), 1'b0, 1, 1'b1);
    applyStimulus(0, 1'b1, 1'b0, 4'd4, '0, lat);
    checkOutput("latency", lat, 5);

    $display("[TB] simultaneous read and write");
    doReset();
`ifdef L2_ARB_FIXED_PRIO_EN
    expectTxn(1, 1'b1, 4'd8, pat(8'h55), pat(8'h5A), 1'b1, 1, 1'b1);
    expectTxn(0, 1'b0, 4'd4, '0, pat(8'hA5), 1'b0, 1, 1'b1);
`else
    expectTxn(0, 1'b0, 4'd4, '0, pat(8'hA5), 1'b0, 1, 1'b1);
    expectTxn(1, 1'b1, 4'd8, pat(8'h55), pat(8'h5A), 1'b1, 1, 1'b1);
`endif
    fork
      begin int l; applyStimulus(0, 1'b1, 1'b0, 4'd4, pat(8'h99), l); end
      begin int l; applyStimulus(1, 1'b0, 1'b1, 4'd8, pat(8'h55), l); end
    join

    $display("[TB] read and write together counts as write");
    expectTxn(1, 1'b1, 4'd2, pat(8'h3C), pat(8'h21), 1'b1, 1, 1'b1);
    applyStimulus(1, 1'b1, 1'b1, 4'd2, pat(8'h3C), lat);

    $display("[TB] continuous requests from both sides");
    doReset();
    for (int i = 0; i < 3; i++) begin
`ifdef L2_ARB_FIXED_PRIO_EN
      expectTxn(1, 1'b1, AW'(8 + i), pat(8'h10 + 8'(i)), pat(8'hD0 + 8'(i)), i[0], 1, 1'b1);
      expectTxn(0, 1'b0, AW'(i), '0, pat(8'hC0 + 8'(i)), ~i[0], 1, 1'b1);
`else
      expectTxn(0, 1'b0, AW'(i), '0, pat(8'hC0 + 8'(i)), ~i[0], 1, 1'b1);
      expectTxn(1, 1'b1, AW'(8 + i), pat(8'h10 + 8'(i)), pat(8'hD0 + 8'(i)), i[0], 1, 1'b1);
`endif
    end
    fork
      begin
        int l;
        for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 1'b0, AW'(i), '0, l);
      end
      begin
        int l;
        for (int i = 0; i < 3; i++) applyStimulus(1, 1'b0, 1'b1, AW'(8 + i), pat(8'h10 + 8'(i)), l);
      end
    join

    $display("[TB] long L2 stall");
    expectTxn(1, 1'b0, 4'd6, '0, pat(8'h77), 1'b1, 11, 1'b1);
    applyStimulus(1, 1'b1, 1'b0, 4'd6, '0, lat);
    checkOutput("stall_latency", lat, 15);

    $display("[TB] reset during transaction");
    expectTxn(0, 1'b0, 4'd3, '0, pat(8'hEE), 1'b1, 20, 1'b0);
    expectTxn(0, 1'b0, 4'd3, '0, pat(8'h4B), 1'b1, 1, 1'b1);
    fork
      begin int l; applyStimulus(0, 1'b1, 1'b0, 4'd3, '0, l); end
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (bus.l2_read) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) checkOutput("abort_issue_timeout", 0, 1);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkResetValues();
        last_out[0] = '0;
        last_out[1] = '0;
        @(posedge clk); #1 rst = 1'b0;
      end
    join

    repeat (5) @(posedge clk);
    checkOutput("l2_queue_drained", l2_q.size(), 0);
    checkOutput("done_queue_drained", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/l2_port_arbiter.md
L2_PORT_ARBITER -- requirements
Module: l2_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, byte width of one block word.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, request address width.
REQ-003 The block SHALL have parameter BLOCK_SIZE, default 8, words per block; block buses are BW = BLOCK_SIZE*DATA_WIDTH bits, flat.
REQ-004 The block SHALL have one clock and a synchronous active-high reset: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-005 Per requester n in {0,1} (0 = L1 I-side, 1 = L1 D-side): rn_addr in ADDR_WIDTH; rn_data_in in BW; rn_read in 1; rn_write in 1; rn_data_out out BW; rn_hit out 1; rn_done out 1.
REQ-006 L2 side: l2_addr out ADDR_WIDTH; l2_data_in out BW; l2_read out 1; l2_write out 1; l2_ready in 1; l2_hit in 1; l2_block_data_out in BW; l2_block_valid in 1.
REQ-007 Status: grant out 2 (one-hot owner, 0 when idle); busy out 1.

Function
REQ-008 A requester SHALL hold rn_read or rn_write high, with stable addr/data, until its rn_done pulse; it SHALL drop the request the cycle after rn_done.
REQ-009 rn_read and rn_write both high SHALL be treated as a write.
REQ-010 FSM states SHALL be IDLE, ISSUE, ACCEPT, COMPLETE, RESP.
REQ-011 IDLE: if any request pending and l2_ready=1, select winner, latch its addr/data/op, set grant, go ISSUE; otherwise stay.
REQ-012 Both pending SHALL resolve round-robin: winner is the requester not granted most recently; rr pointer updates on each grant.
REQ-013 ISSUE: assert exactly one of l2_read/l2_write for exactly one cycle with latched l2_addr/l2_data_in; go ACCEPT.
REQ-014 ACCEPT: wait for l2_ready=0 (L2 accepted), then go COMPLETE.
REQ-015 COMPLETE: wait for l2_ready=1; on that cycle capture l2_block_data_out and l2_hit; go RESP.
REQ-016 RESP: pulse rn_done for the owner only, one cycle; rn_data_out and rn_hit valid that cycle and held until next capture; clear grant; go IDLE.
REQ-017 Minimum request-to-done latency SHALL be 5 cycles (IDLE sample, ISSUE, ACCEPT, COMPLETE, RESP).
REQ-018 l2_addr/l2_data_in SHALL remain stable from ISSUE through COMPLETE.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 A request arriving while busy SHALL wait; it SHALL never be dropped or duplicated.
REQ-021 The non-owner's rn_done SHALL stay 0 and its rn_data_out SHALL not change.
REQ-022 l2_block_valid SHALL be ignored for sequencing.

Reset
REQ-023 While rst=1 at a clk edge: state IDLE, grant 0, busy 0, l2_read 0, l2_write 0, r0_done 0, r1_done 0, r0_hit 0, r1_hit 0, rn_data_out 0, l2_addr 0, l2_data_in 0, rr pointer favouring requester 0.
REQ-024 Reset mid-transaction SHALL abort with no rn_done pulse; requesters re-arbitrate after reset release.

Configuration
REQ-025 Macro L2_ARB_FIXED_PRIO_EN SHALL select arbitration policy.
REQ-026 With L2_ARB_FIXED_PRIO_EN defined, requester 1 SHALL always win simultaneous requests and the rr pointer SHALL be absent.
REQ-027 Without L2_ARB_FIXED_PRIO_EN, round-robin per REQ-012 SHALL apply.

Verification
REQ-028 Reset, then r0_read addr=4, L2 drops ready 1 cycle then returns ready with block all 0xAA, hit=0 -> single l2_read pulse with l2_addr=4, r0_done once 5 cycles after request, r0_data_out all 0xAA, r0_hit=0.
REQ-029 r0_read addr=4 and r1_write addr=8 data all 0x55 same cycle (round-robin, after reset) -> r0 served first, then one l2_write pulse with l2_addr=8 and l2_data_in all 0x55, r1_done after r0_done; with L2_ARB_FIXED_PRIO_EN order reverses.
REQ-030 Both requesters continuously requesting for 6 transactions -> grant alternates 01,10,01,10,01,10; no l2_read/l2_write pulse longer than 1 cycle.
REQ-031 r1_read and r1_write both high addr=2 -> l2_write pulse only, l2_read stays 0.
REQ-032 rst asserted in COMPLETE -> next cycle all outputs at reset values, no rn_done; held request re-issued after release.
REQ-033 L2 holds ready=0 for 10 cycles in COMPLETE -> busy stays 1, l2_addr stable, no rn_done until ready returns.
